// File: rtl/eth_tx_pkg.sv
// Shared definitions between the UDP payload feeder and the MII frame sender:
// sender state codes and protocol header sizes.
package eth_tx_pkg;

    localparam logic [3:0] TX_IDLE     = 4'd0;
    localparam logic [3:0] TX_PREAMBLE = 4'd1;
    localparam logic [3:0] TX_MAC_HDR  = 4'd2;
    localparam logic [3:0] TX_IP_HDR   = 4'd3;
    localparam logic [3:0] TX_UDP_HDR  = 4'd4;
    localparam logic [3:0] TX_PAYLOAD  = 4'd5;
    localparam logic [3:0] TX_CRC      = 4'd6;

    localparam int unsigned UDP_HDR_BYTES = 8;
    localparam int unsigned IP_HDR_BYTES  = 20;

    function automatic logic [15:0] udp_length(input logic [10:0] payload_bytes);
        return {5'd0, payload_bytes} + 16'(UDP_HDR_BYTES);
    endfunction

    function automatic logic [15:0] ip_length(input logic [10:0] payload_bytes);
        return {5'd0, payload_bytes} + 16'(UDP_HDR_BYTES + IP_HDR_BYTES);
    endfunction

endpackage

// File: rtl/udp_payload_ram.sv
// 512x32 simple dual-port payload buffer with byte-lane write enables and a
// registered read port; reads that collide with a write return the old word.
module udp_payload_ram (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [8:0]  wr_addr,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic [8:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [512];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Word 0 is never written by the packer, so it always reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'd0;
        end else begin
            rd_data <= (rd_addr == 9'd0) ? 32'd0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_tx_payload_buf.sv
// Byte-stream packer feeding the MII UDP sender: packs payload big-endian into the
// payload RAM, pads to the minimum length and holds the frame until it is consumed.
module udp_tx_payload_buf
    import eth_tx_pkg::*;
#(
    parameter int unsigned MIN_PAYLOAD = 18,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter logic [3:0]  IDLE_CODE   = TX_IDLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    input  logic [8:0]  ram_rd_addr,
    output logic [31:0] datain,
    input  logic [3:0]  tx_state,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        frame_ready,
    output logic        overflow,
    output logic        tx_collide
);

    localparam logic [1:0] StFill    = 2'd0;
    localparam logic [1:0] StPad     = 2'd1;
    localparam logic [1:0] StLocked  = 2'd2;
    localparam logic [1:0] StSending = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        wr_ready_q;
    logic        overflow_q, overflow_d;
    logic        collide_q, collide_d;
    logic [15:0] udp_len_q, ip_len_q;

    logic        accept;
    logic        ram_we;
    logic [7:0]  ram_byte;
    logic [8:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;

    assign accept = wr_valid && wr_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        collide_d  = collide_q;
        ram_we     = 1'b0;
        ram_byte   = 8'd0;
        unique case (state_q)
            StFill: begin
                if (tx_state != IDLE_CODE) collide_d = 1'b1;
                if (accept) begin
                    if (cnt_q < 11'(MAX_PAYLOAD)) begin
                        ram_we   = 1'b1;
                        ram_byte = wr_data;
                        cnt_d    = cnt_q + 11'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (wr_last) begin
                        state_d = (cnt_q + 11'd1 < 11'(MIN_PAYLOAD)) ? StPad : StLocked;
                    end
                end
            end
            StPad: begin
                if (tx_state != IDLE_CODE) collide_d = 1'b1;
                if (cnt_q < 11'(MIN_PAYLOAD)) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 11'd1;
                end
                if (cnt_d == 11'(MIN_PAYLOAD)) state_d = StLocked;
            end
            StLocked: begin
                if (tx_state != IDLE_CODE) state_d = StSending;
            end
            StSending: begin
                if (tx_state == IDLE_CODE) begin
                    state_d = StFill;
                    cnt_d   = 11'd0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Lane 3 opens a new word: write all four lanes so the tail reads as zero.
    always_comb begin
        ram_addr = 9'd1 + 9'(cnt_q >> 2);
        if (cnt_q[1:0] == 2'd0) begin
            ram_be    = 4'b1111;
            ram_wdata = {ram_byte, 24'd0};
        end else begin
            ram_be    = 4'b1000 >> cnt_q[1:0];
            ram_wdata = {4{ram_byte}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            cnt_q      <= 11'd0;
            wr_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            collide_q  <= 1'b0;
            udp_len_q  <= 16'd0;
            ip_len_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ready_q <= (state_d == StFill);
            overflow_q <= overflow_d;
            collide_q  <= collide_d;
            if (state_d == StLocked && state_q != StLocked) begin
                udp_len_q <= udp_length(cnt_d);
                ip_len_q  <= ip_length(cnt_d);
            end
        end
    end

    udp_payload_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .wr_addr (ram_addr),
        .wr_be   (ram_be),
        .wr_data (ram_wdata),
        .rd_addr (ram_rd_addr),
        .rd_data (datain)
    );

    assign wr_ready        = wr_ready_q;
    assign frame_ready     = (state_q == StLocked);
    assign overflow        = overflow_q;
    assign tx_collide      = collide_q;
    assign tx_data_length  = udp_len_q;
    assign tx_total_length = ip_len_q;

endmodule

// File: tb/tb_udp_tx_payload_buf.sv
// Directed bench for udp_tx_payload_buf: packing, padding, consumption handshake,
// overflow, sender collision and mid-frame reset.
module tb_udp_tx_payload_buf;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic [8:0]  ram_rd_addr;
    logic [31:0] datain;
    logic [3:0]  tx_state;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        frame_ready;
    logic        overflow;
    logic        tx_collide;

    int vectors;
    int miscompares;

    udp_tx_payload_buf dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_last         (wr_last),
        .wr_ready        (wr_ready),
        .ram_rd_addr     (ram_rd_addr),
        .datain          (datain),
        .tx_state        (tx_state),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .frame_ready     (frame_ready),
        .overflow        (overflow),
        .tx_collide      (tx_collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [8:0] a, input logic [31:0] exp);
        ram_rd_addr = a;
        tick();
        check(tag, datain, exp);
    endtask

    task automatic consume();
        tx_state = 4'd1;
        tick();
        tx_state = 4'd0;
        tick();
        check("consume_wr_ready", {31'd0, wr_ready}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = 8'd0;
        wr_last     = 1'b0;
        ram_rd_addr = 9'd0;
        tx_state    = 4'd0;

        // Reset state
        #12;
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
        check("rst_udp_len", {16'd0, tx_data_length}, 32'd0);
        check("rst_ip_len", {16'd0, tx_total_length}, 32'd0);
        check("rst_flags", {30'd0, overflow, tx_collide}, 32'd0);
        check("rst_datain", datain, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        check("wr_ready_after_release", {31'd0, wr_ready}, 32'd1);

        // Case 1: short frame, padded to 18 bytes
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        check("c1_pad_wr_ready", {31'd0, wr_ready}, 32'd0);
        repeat (16) tick();
        check("c1_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("c1_udp_len", {16'd0, tx_data_length}, 32'd26);
        check("c1_ip_len", {16'd0, tx_total_length}, 32'd46);
        read_word("c1_word1", 9'd1, 32'h11223344);
        read_word("c1_word2", 9'd2, 32'h0);
        read_word("c1_word3", 9'd3, 32'h0);
        read_word("c1_word4", 9'd4, 32'h0);
        read_word("c1_word5", 9'd5, 32'h0);
        read_word("c1_word0", 9'd0, 32'h0);
        // Writes while not ready are ignored
        send(8'hEE, 1'b1);
        read_word("ignored_word1", 9'd1, 32'h11223344);
        check("ignored_frame_ready", {31'd0, frame_ready}, 32'd1);

        // Case 3: sender walks the frame then returns to idle
        tx_state = 4'd1;
        tick();
        check("c3_frame_ready_fall", {31'd0, frame_ready}, 32'd0);
        for (int s = 2; s <= 6; s++) begin
            tx_state = 4'(s);
            tick();
            check("c3_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        end
        check("c3_udp_len_held", {16'd0, tx_data_length}, 32'd26);
        check("c3_collide_clear", {31'd0, tx_collide}, 32'd0);
        tx_state = 4'd0;
        tick();
        check("c3_wr_ready_back", {31'd0, wr_ready}, 32'd1);

        // Case 2: 22 bytes, no padding
        for (int k = 0; k < 22; k++) send(8'(k), k == 21);
        check("c2_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("c2_udp_len", {16'd0, tx_data_length}, 32'd30);
        check("c2_ip_len", {16'd0, tx_total_length}, 32'd50);
        read_word("c2_word1", 9'd1, 32'h00010203);
        read_word("c2_word6", 9'd6, 32'h14150000);
        consume();

        // Case 4: overflow beyond the maximum payload
        for (int k = 0; k < 1474; k++) begin
            send(8'(k), k == 1473);
            if (k == 1471) check("c4_no_overflow_yet", {31'd0, overflow}, 32'd0);
            if (k == 1472) begin
                check("c4_overflow_set", {31'd0, overflow}, 32'd1);
                check("c4_still_ready", {31'd0, wr_ready}, 32'd1);
            end
        end
        check("c4_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("c4_udp_len", {16'd0, tx_data_length}, 32'd1480);
        check("c4_ip_len", {16'd0, tx_total_length}, 32'd1500);
        read_word("c4_word368", 9'd368, 32'hBCBDBEBF);
        read_word("c4_word1", 9'd1, 32'h00010203);
        consume();
        check("c4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Case 5: sender leaves idle while filling
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        tx_state = 4'd1;
        send(8'hA2, 1'b0);
        tx_state = 4'd0;
        check("c5_collide", {31'd0, tx_collide}, 32'd1);
        check("c5_still_filling", {31'd0, wr_ready}, 32'd1);
        for (int k = 3; k < 20; k++) send(8'hA0 + 8'(k), k == 19);
        check("c5_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("c5_udp_len", {16'd0, tx_data_length}, 32'd28);
        read_word("c5_word1", 9'd1, 32'hA0A1A2A3);
        consume();

        // Case 6: reset during padding
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        ram_rd_addr = 9'd1;
        tick();
        tick();
        check("c6_in_pad", {31'd0, wr_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        check("c6_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("c6_rst_frame_ready", {31'd0, frame_ready}, 32'd0);
        check("c6_rst_lengths", {tx_data_length, tx_total_length}, 32'd0);
        check("c6_rst_flags", {30'd0, overflow, tx_collide}, 32'd0);
        check("c6_rst_datain", datain, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("c6_wr_ready_release", {31'd0, wr_ready}, 32'd1);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        repeat (16) tick();
        check("c6_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("c6_udp_len", {16'd0, tx_data_length}, 32'd26);
        check("c6_ip_len", {16'd0, tx_total_length}, 32'd46);
        read_word("c6_word1", 9'd1, 32'h55667788);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
